// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: elastic-stage state encoding and default widths.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int LEN_WORD          = 32;
  localparam int LEN_REG_FILE_ADDR = 5;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between an upstream stage, the register and downstream.
interface pipe_stage_reg_if #(
  parameter int LEN_DATA = 32,
  parameter int LEN_CTRL = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [LEN_DATA-1:0] in_data;
  logic [LEN_CTRL-1:0] in_ctrl;
  logic                out_valid;
  logic                out_ready;
  logic [LEN_DATA-1:0] out_data;
  logic [LEN_CTRL-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_slot.sv
// One {valid, ctrl, data} holding register; clear kills the beat but leaves the payload.
module pipe_slot #(
  parameter int LEN_DATA = 32,
  parameter int LEN_CTRL = 4
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic [LEN_DATA-1:0] i_data,
  input  logic [LEN_CTRL-1:0] i_ctrl,
  output logic                o_valid,
  output logic [LEN_DATA-1:0] o_data,
  output logic [LEN_CTRL-1:0] o_ctrl
);

  logic                r_valid;
  logic [LEN_DATA-1:0] r_data;
  logic [LEN_CTRL-1:0] r_ctrl;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: main slot plus optional skid slot, flush, and a
// saturating stall counter. Empty or flushed slots present zero control (NOP bubble).
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int LEN_DATA = LEN_WORD,
  parameter int LEN_CTRL = 4,
  parameter int SKID     = 1,
  parameter int LEN_CNT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_reg_if.slave    ifc,
  output logic [LEN_CNT-1:0] stall_cnt
);

  function automatic logic [LEN_CNT-1:0] sat_inc(input logic [LEN_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              r_state;
  logic [LEN_CNT-1:0]  r_stall_cnt;

  logic                w_in_ready, w_slot_free, w_in_fire, w_out_fire;
  logic                w_main_valid, w_skid_valid;
  logic [LEN_DATA-1:0] w_main_data, w_skid_data, w_main_din;
  logic [LEN_CTRL-1:0] w_main_ctrl, w_skid_ctrl, w_main_cin;
  logic                w_main_load, w_main_clear, w_skid_load, w_skid_clear;

  // With a skid slot in_ready depends only on registered state; without one it
  // must look at out_ready so a full slot can still swap in the same cycle.
  assign w_slot_free = (SKID != 0) ? ~w_skid_valid : (ifc.out_ready | ~w_main_valid);
  assign w_in_ready  = ~reset & ~flush & w_slot_free;
  assign w_in_fire   = ifc.in_valid & w_in_ready;
  assign w_out_fire  = w_main_valid & ifc.out_ready;

  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = flush;
    w_skid_load  = 1'b0;
    w_skid_clear = flush;
    w_main_din   = ifc.in_data;
    w_main_cin   = ifc.in_ctrl;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_main_load = w_in_fire;
        ST_FULL: begin
          w_main_load  = w_in_fire & w_out_fire;
          w_main_clear = w_out_fire & ~w_in_fire;
          w_skid_load  = w_in_fire & ~w_out_fire;
        end
        ST_SKID: begin
          w_main_load  = w_out_fire;
          w_skid_clear = w_out_fire;
          w_main_din   = w_skid_data;
          w_main_cin   = w_skid_ctrl;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) r_state <= ST_FULL;
        ST_FULL: begin
          if (w_in_fire && !w_out_fire)
            r_state <= (SKID != 0) ? ST_SKID : ST_FULL;
          else if (!w_in_fire && w_out_fire)
            r_state <= ST_EMPTY;
        end
        ST_SKID:  if (w_out_fire) r_state <= ST_FULL;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_main_valid && !ifc.out_ready)
      r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  pipe_slot #(.LEN_DATA(LEN_DATA), .LEN_CTRL(LEN_CTRL)) u_main (
    .clk     (clk),
    .i_rst   (reset),
    .i_clear (w_main_clear),
    .i_load  (w_main_load),
    .i_data  (w_main_din),
    .i_ctrl  (w_main_cin),
    .o_valid (w_main_valid),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.LEN_DATA(LEN_DATA), .LEN_CTRL(LEN_CTRL)) u_skid (
        .clk     (clk),
        .i_rst   (reset),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_data  (ifc.in_data),
        .i_ctrl  (ifc.in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
      );
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign w_skid_ctrl  = '0;
    end
  endgenerate

  assign ifc.in_ready  = w_in_ready;
  assign ifc.out_valid = w_main_valid;
  assign ifc.out_data  = w_main_data;
  assign ifc.out_ctrl  = w_main_ctrl & {LEN_CTRL{w_main_valid}};
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, no-skid and narrow-counter instances on one clock.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [15:0] stall_a, stall_b;
  logic [2:0]  stall_c;

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.LEN_DATA(32), .LEN_CTRL(4)) if_a ();
  pipe_stage_reg_if #(.LEN_DATA(32), .LEN_CTRL(4)) if_b ();
  pipe_stage_reg_if #(.LEN_DATA(32), .LEN_CTRL(4)) if_c ();

  pipe_stage_reg #(.LEN_DATA(32), .LEN_CTRL(4), .SKID(1), .LEN_CNT(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .ifc(if_a.slave), .stall_cnt(stall_a));
  pipe_stage_reg #(.LEN_DATA(32), .LEN_CTRL(4), .SKID(0), .LEN_CNT(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .ifc(if_b.slave), .stall_cnt(stall_b));
  pipe_stage_reg #(.LEN_DATA(32), .LEN_CTRL(4), .SKID(1), .LEN_CNT(3)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .ifc(if_c.slave), .stall_cnt(stall_c));

  task automatic drive_a(input logic v, input logic [31:0] d, input logic [3:0] c, input logic r);
    if_a.in_valid = v; if_a.in_data = d; if_a.in_ctrl = c; if_a.out_ready = r;
  endtask
  task automatic drive_b(input logic v, input logic [31:0] d, input logic [3:0] c, input logic r);
    if_b.in_valid = v; if_b.in_data = d; if_b.in_ctrl = c; if_b.out_ready = r;
  endtask
  task automatic drive_c(input logic v, input logic [31:0] d, input logic [3:0] c, input logic r);
    if_c.in_valid = v; if_c.in_data = d; if_c.in_ctrl = c; if_c.out_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0;
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0); drive_c(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0); drive_c(0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if ({if_a.in_ready, if_b.in_ready, if_c.in_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=000", {if_a.in_ready, if_b.in_ready, if_c.in_ready}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if ({if_a.in_ready, if_b.in_ready, if_c.in_ready} !== 3'b111) begin
      n_err++; $display("FAIL post_reset_in_ready got=%b exp=111", {if_a.in_ready, if_b.in_ready, if_c.in_ready}); end
    n_vec++; if ({if_a.out_valid, if_a.out_data, if_a.out_ctrl, stall_a} !== 53'd0) begin
      n_err++; $display("FAIL reset_outputs got v=%b d=%h c=%h s=%0d exp all zero",
                        if_a.out_valid, if_a.out_data, if_a.out_ctrl, stall_a); end
  endtask

  task automatic test_stream();
    logic [35:0] e;
    do_reset();
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      drive_a(cyc < 8, 32'(32'h10 + cyc), 4'(cyc + 1), 1'b1);
      #1;
      n_vec++; if (if_a.out_valid !== (cyc >= 1 && cyc <= 8)) begin
        n_err++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%b", cyc, if_a.out_valid, (cyc >= 1 && cyc <= 8)); end
      if (cyc < 8) begin
        n_vec++; if (if_a.in_ready !== 1'b1) begin
          n_err++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", cyc, if_a.in_ready); end
      end
      if (if_a.out_valid && if_a.out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stream_extra cyc=%0d got=%h exp=none", cyc, if_a.out_data);
        end else begin
          e = sb.pop_front();
          if ({if_a.out_ctrl, if_a.out_data} !== e) begin
            n_err++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, {if_a.out_ctrl, if_a.out_data}, e); end
        end
      end
      if (if_a.in_valid && if_a.in_ready) sb.push_back({if_a.in_ctrl, if_a.in_data});
    end
    n_vec++; if (stall_a !== 16'd0) begin
      n_err++; $display("FAIL stream_stall got=%0d exp=0", stall_a); end
  endtask

  task automatic test_backpressure_skid();
    logic [35:0] e;
    int idx = 0;
    int n_out = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      drive_a(idx < 8, 32'(32'h20 + idx), 4'(idx), !(cyc >= 3 && cyc <= 5));
      #1;
      if (cyc == 3) begin
        n_vec++; if (if_a.in_ready !== 1'b1) begin
          n_err++; $display("FAIL skid_absorb_ready got=%b exp=1", if_a.in_ready); end
      end
      if (cyc == 4) begin
        n_vec++; if (if_a.in_ready !== 1'b0) begin
          n_err++; $display("FAIL skid_full_ready got=%b exp=0", if_a.in_ready); end
      end
      if (if_a.out_valid && if_a.out_ready) begin
        n_vec++; n_out++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL skid_extra cyc=%0d got=%h exp=none", cyc, if_a.out_data);
        end else begin
          e = sb.pop_front();
          if ({if_a.out_ctrl, if_a.out_data} !== e) begin
            n_err++; $display("FAIL skid_order cyc=%0d got=%h exp=%h", cyc, {if_a.out_ctrl, if_a.out_data}, e); end
        end
      end
      if (if_a.in_valid && if_a.in_ready) begin
        sb.push_back({if_a.in_ctrl, if_a.in_data});
        idx++;
      end
    end
    n_vec++; if (n_out != 8) begin
      n_err++; $display("FAIL skid_count got=%0d exp=8", n_out); end
    n_vec++; if (stall_a !== 16'd3) begin
      n_err++; $display("FAIL skid_stall got=%0d exp=3", stall_a); end
  endtask

  task automatic test_backpressure_noskid();
    logic [35:0] e;
    int idx = 0;
    int n_out = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      drive_b(idx < 8, 32'(32'h20 + idx), 4'(idx), !(cyc >= 3 && cyc <= 5));
      #1;
      n_vec++; if (if_b.in_ready !== (if_b.out_ready | ~if_b.out_valid)) begin
        n_err++; $display("FAIL noskid_ready cyc=%0d got=%b exp=%b", cyc, if_b.in_ready, (if_b.out_ready | ~if_b.out_valid)); end
      if (cyc == 3) begin
        n_vec++; if (if_b.in_ready !== 1'b0) begin
          n_err++; $display("FAIL noskid_stall_ready got=%b exp=0", if_b.in_ready); end
      end
      if (if_b.out_valid && if_b.out_ready) begin
        n_vec++; n_out++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL noskid_extra cyc=%0d got=%h exp=none", cyc, if_b.out_data);
        end else begin
          e = sb.pop_front();
          if ({if_b.out_ctrl, if_b.out_data} !== e) begin
            n_err++; $display("FAIL noskid_order cyc=%0d got=%h exp=%h", cyc, {if_b.out_ctrl, if_b.out_data}, e); end
        end
      end
      if (if_b.in_valid && if_b.in_ready) begin
        sb.push_back({if_b.in_ctrl, if_b.in_data});
        idx++;
      end
    end
    n_vec++; if (n_out != 8) begin
      n_err++; $display("FAIL noskid_count got=%0d exp=8", n_out); end
    n_vec++; if (stall_b !== 16'd3) begin
      n_err++; $display("FAIL noskid_stall got=%0d exp=3", stall_b); end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk); drive_a(1, 32'h55, 4'b1010, 0);
    @(negedge clk); drive_a(1, 32'h66, 4'b1010, 0); #1;
    n_vec++; if ({if_a.out_valid, if_a.out_ctrl, if_a.out_data, if_a.in_ready} !== {1'b1, 4'b1010, 32'h55, 1'b1}) begin
      n_err++; $display("FAIL flush_setup got v=%b c=%b d=%h r=%b exp v=1 c=1010 d=55 r=1",
                        if_a.out_valid, if_a.out_ctrl, if_a.out_data, if_a.in_ready); end
    @(negedge clk); flush = 1'b1; drive_a(1, 32'h77, 4'b0101, 0); #1;
    n_vec++; if (if_a.in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_in_ready got=%b exp=0", if_a.in_ready); end
    @(negedge clk); flush = 1'b0; drive_a(0, 0, 0, 0); #1;
    n_vec++; if ({if_a.out_valid, if_a.out_ctrl, if_a.out_data} !== {1'b0, 4'b0000, 32'h55}) begin
      n_err++; $display("FAIL flush_outputs got v=%b c=%b d=%h exp v=0 c=0000 d=55",
                        if_a.out_valid, if_a.out_ctrl, if_a.out_data); end
    n_vec++; if (stall_a !== 16'd2) begin
      n_err++; $display("FAIL flush_stall got=%0d exp=2", stall_a); end
    @(negedge clk); drive_a(0, 0, 0, 1); #1;
    n_vec++; if (if_a.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_input_dropped got=%b exp=0", if_a.out_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    @(negedge clk); drive_a(1, 32'hA0, 4'b1111, 0);
    @(negedge clk); drive_a(1, 32'hA1, 4'b1111, 0);
    repeat (4) begin @(negedge clk); drive_a(0, 0, 0, 0); end
    @(negedge clk); #1;
    n_vec++; if ({stall_a, if_a.in_ready, if_a.out_valid} !== {16'd5, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL midreset_setup got s=%0d r=%b v=%b exp s=5 r=0 v=1", stall_a, if_a.in_ready, if_a.out_valid); end
    reset = 1'b1; #1;
    n_vec++; if (if_a.in_ready !== 1'b0) begin
      n_err++; $display("FAIL midreset_ready got=%b exp=0", if_a.in_ready); end
    @(negedge clk); reset = 1'b0; #1;
    n_vec++; if ({if_a.out_valid, if_a.out_data, if_a.out_ctrl, stall_a} !== 53'd0) begin
      n_err++; $display("FAIL midreset_outputs got v=%b d=%h c=%h s=%0d exp all zero",
                        if_a.out_valid, if_a.out_data, if_a.out_ctrl, stall_a); end
    n_vec++; if (if_a.in_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_release_ready got=%b exp=1", if_a.in_ready); end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk); drive_c(1, 32'h99, 4'b0011, 0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk); drive_c(0, 0, 0, 0); #1;
      if (cyc == 7) begin
        n_vec++; if (stall_c !== 3'd6) begin
          n_err++; $display("FAIL sat_mid got=%0d exp=6", stall_c); end
      end
    end
    @(negedge clk); drive_c(0, 0, 0, 1); #1;
    n_vec++; if (stall_c !== 3'd7) begin
      n_err++; $display("FAIL sat_value got=%0d exp=7", stall_c); end
    n_vec++; if ({if_c.out_valid, if_c.out_ctrl, if_c.out_data} !== {1'b1, 4'b0011, 32'h99}) begin
      n_err++; $display("FAIL sat_beat got v=%b c=%b d=%h exp v=1 c=0011 d=99", if_c.out_valid, if_c.out_ctrl, if_c.out_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure_skid();
    test_backpressure_noskid();
    test_flush();
    test_reset_midstream();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register; the next generation of the fixed inter-stage registers (ID/EX, EX/MEM, MEM/WB). It carries a generic data payload plus control bits between two stages, adds valid/ready back-pressure, stall and flush, an optional skid slot for full throughput with a registered `in_ready`, and a saturating stall counter. Flushed and empty slots present all-zero control bits, so downstream sees a NOP bubble.

## Interface
- `LEN_DATA`, 32: payload width (ALU result, store data, register addresses, concatenated).
- `LEN_CTRL`, 4: control width (mem_read, mem_write, reg_write, mem_to_reg, ...); zeroed on any bubble.
- `SKID`, 1: 0 = single slot, `in_ready` combinational; 1 = main plus skid slot, `in_ready` registered.
- `LEN_CNT`, 16: stall counter width.

- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage accepts the beat this cycle.
- `in_data` in LEN_DATA: payload.
- `in_ctrl` in LEN_CTRL: control bits.
- `flush` in 1: synchronous kill of every held beat (branch or exception).
- `out_valid` out 1: beat presented downstream.
- `out_ready` in 1: downstream consumes the beat.
- `out_data` out LEN_DATA: held payload.
- `out_ctrl` out LEN_CTRL: held control bits; forced 0 when `out_valid`=0.
- `stall_cnt` out LEN_CNT: cycles with `out_valid & ~out_ready`.

## Operation
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- States: EMPTY (no beat), FULL (main slot only), SKID (main and skid slots; SKID=1 only).
- EMPTY: in transfer -> FULL, main <= input.
- FULL: in transfer and out transfer -> FULL, main <= input. Out transfer only -> EMPTY. In transfer only -> SKID, skid <= input.
- SKID: out transfer -> FULL, main <= skid; the skid slot is freed.
- `in_ready`: SKID=1: `~skid_valid` (registered). SKID=0: `out_ready | ~main_valid`, so no SKID state is ever entered.
- `in_ready` is 0 while `reset` or `flush` is high. No accepted beat is ever dropped.
- Flush: next state EMPTY, `out_valid` 0, `out_ctrl` 0. `out_data` keeps its value. A downstream transfer in the flush cycle still completes.
- Priority: reset > flush > normal transfers.
- `stall_cnt`: +1 in each cycle with `out_valid & ~out_ready`. Saturates at 2^LEN_CNT-1. Cleared by reset only; flush does not clear it.
- `out_ctrl` equals the main-slot ctrl ANDed with `out_valid`. The output is a mux of the slot, never a combinational path from the input.

## Timing
- Latency: 1 cycle from in transfer to `out_valid`.
- Throughput: 1 beat/cycle under continuous `out_ready`, for both SKID values.
- SKID=1 absorbs exactly one beat after `out_ready` falls. `in_ready` drops the cycle after the skid slot fills.
- Reset values: `out_valid`=0, `out_data`=0, `out_ctrl`=0, `stall_cnt`=0, state EMPTY, skid slot 0. `in_ready`=0 during reset and 1 in the first cycle after reset.
- Reset mid-stream discards both slots with no partial beat. Flush and `in_valid` in the same cycle: the input is not accepted.
- Beats leave in arrival order. The skid beat is always presented after the main beat.

## Structure
- Shared package `pipeline_pkg` holds:
  - the state encoding: `ST_EMPTY`=2'd0, `ST_FULL`=2'd1, `ST_SKID`=2'd2;
  - the default widths `LEN_WORD`=32 and `LEN_REG_FILE_ADDR`=5.
- Sub-module `pipe_slot`: one `{valid, ctrl, data}` register with load and clear (clear zeroes valid and ctrl only). It is instantiated twice; the skid instance is generated only when SKID=1.
- Top level holds the state machine, `in_ready` logic, output mux and stall counter.

## Test plan
- Stream 8 beats 0x10..0x17 with `out_ready`=1: each appears one cycle later; `out_valid` is continuous; `stall_cnt`=0.
- SKID=1, drop `out_ready` for 3 cycles mid-stream: one beat is absorbed; `in_ready`=0 the next cycle; order is preserved; `stall_cnt`=3.
- SKID=0, same stimulus: `in_ready` follows `out_ready` in the same cycle; no loss; order is preserved.
- Flush while in SKID state holding ctrl=4'b1010: next cycle `out_valid`=0, `out_ctrl`=0; the flush-cycle input is not accepted; `out_data` is unchanged.
- Reset asserted with both slots full and `stall_cnt`=5: next cycle all outputs are 0; `in_ready`=1 one cycle after reset is released.
- LEN_CNT=3, hold `out_valid` with `out_ready`=0 for 10 cycles: `stall_cnt` saturates at 7.
